// File: rtl/pipelined_alu.sv
// Two-stage 8-bit ALU: stage 1 registers operands/opcode, stage 2 registers a
// double-width result. One operation per cycle, fixed two-edge latency.
module pipelined_alu #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  output logic [2*WIDTH-1:0] result
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101
  } alu_op_e;

  logic [WIDTH-1:0]   a_q, b_q;
  logic [2:0]         op_q;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [2*WIDTH-1:0] a_ext, b_ext;

  // Stage 1: capture operands and opcode.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= 3'b000;
    end else begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op;
    end
  end

  assign a_ext = {{WIDTH{1'b0}}, a_q};
  assign b_ext = {{WIDTH{1'b0}}, b_q};

  // Operands are zero-extended first, so SUB wraps modulo 2^(2*WIDTH).
  always_comb begin
    result_d = '0;
    case (op_q)
      OP_ADD:  result_d = a_ext + b_ext;
      OP_SUB:  result_d = a_ext - b_ext;
      OP_MUL:  result_d = a_ext * b_ext;
      OP_AND:  result_d = a_ext & b_ext;
      OP_OR:   result_d = a_ext | b_ext;
      OP_XOR:  result_d = a_ext ^ b_ext;
      default: result_d = '0;
    endcase
  end

  // Stage 2: register the result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// Scoreboard bench for pipelined_alu: the driver queues the expected result for
// every edge it drives; a negedge monitor pops and compares.
module tb_pipelined_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  a, b;
  logic [2:0]  op;
  logic [15:0] result;

  int checks = 0;
  int passes = 0;
  int edge_cnt = 0;

  typedef struct {
    int          due;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  // Previous driven sample: what stage 1 holds when the next edge arrives.
  int   prev_a = 0, prev_b = 0, prev_op = 0;
  logic prev_rst = 1'b0;

  pipelined_alu #(.WIDTH(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .op     (op),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [15:0] ref_alu(input int ai, input int bi, input int opi);
    case (opi)
      0: return 16'((ai + bi) & 32'hFFFF);
      1: return 16'((ai - bi) & 32'hFFFF);
      2: return 16'((ai * bi) & 32'hFFFF);
      3: return 16'(ai & bi);
      4: return 16'(ai | bi);
      5: return 16'(ai ^ bi);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic string op_name(input int opi, input logic rsti, input logic prst);
    if (!rsti || !prst) return "RST";
    case (opi)
      0: return "ADD";
      1: return "SUB";
      2: return "MUL";
      3: return "AND";
      4: return "OR";
      5: return "XOR";
      default: return "RSV";
    endcase
  endfunction

  // Drive one cycle of inputs and queue the result expected after the next edge.
  task automatic drive(input logic [7:0] ai, input logic [7:0] bi,
                       input logic [2:0] opi, input logic rsti);
    exp_t e;
    @(negedge clk);
    a = ai; b = bi; op = opi; reset = rsti;
    e.due  = edge_cnt + 1;
    e.val  = (!rsti || !prev_rst) ? 16'h0000 : ref_alu(prev_a, prev_b, prev_op);
    e.name = op_name(prev_op, rsti, prev_rst);
    exp_q.push_back(e);
    prev_a = int'(ai); prev_b = int'(bi); prev_op = int'(opi); prev_rst = rsti;
  endtask

  // Monitor: compare every result whose due edge has just passed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
        e = exp_q.pop_front();
        checks++;
        if (e.due != edge_cnt) begin
          $display("FAIL %s stale expectation: due edge %0d, now edge %0d", e.name, e.due, edge_cnt);
        end else if (result !== e.val) begin
          $display("FAIL %s edge %0d: got %h expected %h", e.name, edge_cnt, result, e.val);
        end else begin
          passes++;
          $display("edge %0d %s result=%h ok", edge_cnt, e.name, result);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; a = 8'h00; b = 8'h00; op = 3'b000;

    // Reset with a MUL pending on the inputs, then release with zero inputs.
    drive(8'hFF, 8'hFF, 3'b010, 1'b0);
    drive(8'hFF, 8'hFF, 3'b010, 1'b0);
    drive(8'h00, 8'h00, 3'b000, 1'b1);
    drive(8'h00, 8'h00, 3'b000, 1'b1);

    // Back-to-back ADD for latency.
    drive(8'd10, 8'd5,  3'b000, 1'b1);
    drive(8'd20, 8'd15, 3'b000, 1'b1);

    // SUB, MUL, logic, reserved.
    drive(8'd20,  8'd5,   3'b001, 1'b1);
    drive(8'd50,  8'd25,  3'b001, 1'b1);
    drive(8'd5,   8'd20,  3'b001, 1'b1);
    drive(8'd3,   8'd4,   3'b010, 1'b1);
    drive(8'd10,  8'd10,  3'b010, 1'b1);
    drive(8'd255, 8'd255, 3'b010, 1'b1);
    drive(8'hAA,  8'hCC,  3'b011, 1'b1);
    drive(8'hAA,  8'hCC,  3'b100, 1'b1);
    drive(8'hAA,  8'hCC,  3'b101, 1'b1);
    drive(8'hAA,  8'hCC,  3'b110, 1'b1);
    drive(8'hAA,  8'hCC,  3'b111, 1'b1);
    drive(8'd255, 8'd255, 3'b000, 1'b1);
    drive(8'd0,   8'd0,   3'b000, 1'b1);

    // Mid-stream reset: the 255+255 must be flushed and never appear.
    drive(8'd255, 8'd255, 3'b000, 1'b1);
    drive(8'd7,   8'd9,   3'b010, 1'b0);
    drive(8'd1,   8'd2,   3'b000, 1'b1);
    drive(8'd3,   8'd4,   3'b000, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      drive(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 31) != 0));
    end
    drive(8'd0, 8'd0, 3'b000, 1'b1);

    // Bounded drain of outstanding expectations.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
